wd_supervisor: RTL and testbench

WD_SUPERVISOR -- requirements
Module: wd_supervisor

---
 rtl/wd_pkg.sv | 23 ++
 rtl/wd_sat_cnt.sv | 28 ++
 rtl/wd_supervisor.sv | 125 ++++++++++++
 tb/tb_wd_supervisor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/wd_pkg.sv
// wd_pkg: shared definitions for the watchdog supervisor.
//   - wd_state_e      : FSM state encoding (IDLE/ARMED/WARN/TRIP)
//   - WD_*_TICKS_DEF  : default warning / timeout tick thresholds, shared
//                       with the tick generator and benches
//   - sat_inc8        : 8-bit increment that sticks at 8'hFF
package wd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    WARN  = 2'b10,
    TRIP  = 2'b11
  } wd_state_e;

  localparam logic [7:0] WD_WARN_TICKS_DEF    = 8'd32;
  localparam logic [7:0] WD_TIMEOUT_TICKS_DEF = 8'd40;
  localparam logic [7:0] WD_CNT_MAX           = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == WD_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wd_sat_cnt.sv
// wd_sat_cnt: 8-bit saturating counter with synchronous clear.
// Ports:
//   clk_i  - clock
//   rst_ni - async active-low reset (count -> 0)
//   clr_i  - synchronous clear, wins over inc_i
//   inc_i  - increment by one, holding at 8'hFF
//   cnt_o  - current count
module wd_sat_cnt
  import wd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= sat_inc8(cnt_q);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wd_supervisor.sv
// wd_supervisor: counts missed watchdog ticks between heartbeats and
// escalates IDLE -> ARMED -> WARN -> TRIP. TRIP is latched until clr_fault
// or reset.
// Ports:
//   adc_clk   - clock
//   rst_n     - async active-low reset
//   wd_stp    - tick strobe (every high cycle counts as one tick)
//   heartbeat - liveness pulse, clears the count
//   arm       - level, enables supervision
//   clr_fault - pulse, releases a latched TRIP
//   wd_warn   - high in WARN (registered)
//   wd_trip   - high in TRIP (registered), feeds HV shutdown
//   tick_cnt  - missed-tick count
//   wd_kick   - kick line to external watchdog IC
// Optional feature: define WD_KICK_OUT_EN to toggle wd_kick on every tick
// seen in ARMED/WARN; otherwise wd_kick is tied low.
// TIMEOUT_TICKS must be greater than WARN_TICKS.
module wd_supervisor
  import wd_pkg::*;
#(
  parameter logic [7:0] WARN_TICKS    = WD_WARN_TICKS_DEF,
  parameter logic [7:0] TIMEOUT_TICKS = WD_TIMEOUT_TICKS_DEF
) (
  input  logic       adc_clk,
  input  logic       rst_n,
  input  logic       wd_stp,
  input  logic       heartbeat,
  input  logic       arm,
  input  logic       clr_fault,
  output logic       wd_warn,
  output logic       wd_trip,
  output logic [7:0] tick_cnt,
  output logic       wd_kick
);

  wd_state_e  state_q;
  logic       warn_q, trip_q;
  logic       cnt_clr, cnt_inc;
  logic [7:0] cnt_nxt;

  // Counter control. In the supervising states arm=0 and heartbeat both
  // clear, and heartbeat masks a coincident tick.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE:        cnt_clr = 1'b1;
      ARMED, WARN: begin
        if (!arm || heartbeat) cnt_clr = 1'b1;
        else if (wd_stp)       cnt_inc = 1'b1;
      end
      TRIP:        cnt_clr = clr_fault;
      default:     cnt_clr = 1'b1;
    endcase
  end

  wd_sat_cnt u_cnt (
    .clk_i  (adc_clk),
    .rst_ni (rst_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (tick_cnt)
  );

  // Value the counter takes on an increment edge; state thresholds are
  // compared against it so the state moves on the same edge as the count.
  assign cnt_nxt = sat_inc8(tick_cnt);

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      warn_q  <= 1'b0;
      trip_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (arm) state_q <= ARMED;
        ARMED: begin
          if (!arm) state_q <= IDLE;
          else if (!heartbeat && wd_stp && cnt_nxt == WARN_TICKS) begin
            state_q <= WARN;
            warn_q  <= 1'b1;
          end
        end
        WARN: begin
          if (!arm) begin
            state_q <= IDLE;
            warn_q  <= 1'b0;
          end else if (heartbeat) begin
            state_q <= ARMED;
            warn_q  <= 1'b0;
          end else if (wd_stp && cnt_nxt == TIMEOUT_TICKS) begin
            state_q <= TRIP;
            warn_q  <= 1'b0;
            trip_q  <= 1'b1;
          end
        end
        TRIP: if (clr_fault) begin
          state_q <= IDLE;
          trip_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          warn_q  <= 1'b0;
          trip_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wd_warn = warn_q;
  assign wd_trip = trip_q;

`ifdef WD_KICK_OUT_EN
  // Kick stops toggling outside ARMED/WARN so the external IC expires.
  logic kick_q;
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) kick_q <= 1'b0;
    else if ((state_q == ARMED || state_q == WARN) && wd_stp) kick_q <= ~kick_q;
  end
  assign wd_kick = kick_q;
`else
  assign wd_kick = 1'b0;
`endif

endmodule

// File: tb/tb_wd_supervisor.sv
module tb_wd_supervisor;
  import wd_pkg::*;

`ifdef WD_KICK_OUT_EN
  localparam bit KICK_EN = 1'b1;
`else
  localparam bit KICK_EN = 1'b0;
`endif

  logic       adc_clk = 1'b0;
  logic       rst_n, wd_stp, heartbeat, arm, clr_fault;
  logic       wd_warn, wd_trip, wd_kick;
  logic [7:0] tick_cnt;

  logic       s_clr, s_inc;
  logic [7:0] s_cnt;

  int checks = 0;
  int failures = 0;
  int kick_n = 0;   // ticks seen while the bench expects ARMED/WARN
  bit sup = 1'b0;   // bench's own view: FSM in ARMED or WARN

  always #5 adc_clk = ~adc_clk;

  wd_supervisor dut (
    .adc_clk   (adc_clk),
    .rst_n     (rst_n),
    .wd_stp    (wd_stp),
    .heartbeat (heartbeat),
    .arm       (arm),
    .clr_fault (clr_fault),
    .wd_warn   (wd_warn),
    .wd_trip   (wd_trip),
    .tick_cnt  (tick_cnt),
    .wd_kick   (wd_kick)
  );

  wd_sat_cnt u_sat (
    .clk_i  (adc_clk),
    .rst_ni (rst_n),
    .clr_i  (s_clr),
    .inc_i  (s_inc),
    .cnt_o  (s_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge adc_clk);
    if (sup && wd_stp) kick_n++;
    #1;
  endtask

  task automatic ticks(input int n);
    wd_stp = 1'b1;
    repeat (n) step();
    wd_stp = 1'b0;
  endtask

  function automatic logic [7:0] kexp();
    return KICK_EN ? {7'd0, kick_n[0]} : 8'd0;
  endfunction

  task automatic chk_out(input string tag, input logic [7:0] cnt, input logic w, input logic t);
    chk({tag, ".cnt"},  tick_cnt, cnt);
    chk({tag, ".warn"}, {7'd0, wd_warn}, {7'd0, w});
    chk({tag, ".trip"}, {7'd0, wd_trip}, {7'd0, t});
  endtask

  initial begin
    rst_n = 1'b0; wd_stp = 1'b0; heartbeat = 1'b0; arm = 1'b0; clr_fault = 1'b0;
    s_clr = 1'b0; s_inc = 1'b0;
    #3;
    chk_out("reset", 8'd0, 1'b0, 1'b0);
    chk("reset.kick", {7'd0, wd_kick}, 8'd0);
    #9 rst_n = 1'b1;

    // arm, then single ticks with kick tracking
    arm = 1'b1; step(); sup = 1'b1;
    chk_out("armed", 8'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      ticks(1);
      chk("tick.cnt", tick_cnt, i[7:0]);
      chk("tick.kick", {7'd0, wd_kick}, kexp());
    end
    ticks(21);
    chk_out("t31", 8'd31, 1'b0, 1'b0);

    // heartbeat and tick together at 31: heartbeat wins
    heartbeat = 1'b1; wd_stp = 1'b1; step(); heartbeat = 1'b0; wd_stp = 1'b0;
    chk_out("simul", 8'd0, 1'b0, 1'b0);

    // warn threshold exactly at tick 32
    ticks(31);
    chk_out("pre_warn", 8'd31, 1'b0, 1'b0);
    ticks(1);
    chk_out("warn32", 8'd32, 1'b1, 1'b0);
    ticks(1);
    chk_out("warn33", 8'd33, 1'b1, 1'b0);

    // heartbeat recovery from WARN
    heartbeat = 1'b1; step(); heartbeat = 1'b0;
    chk_out("recover", 8'd0, 1'b0, 1'b0);

    // full run to trip
    ticks(32);
    chk_out("rewarn", 8'd32, 1'b1, 1'b0);
    ticks(7);
    chk_out("t39", 8'd39, 1'b1, 1'b0);
    ticks(1); sup = 1'b0;
    chk_out("trip40", 8'd40, 1'b0, 1'b1);
    chk("trip.kick", {7'd0, wd_kick}, kexp());

    // trip is latched against arm/heartbeat/tick
    arm = 1'b0; heartbeat = 1'b1; wd_stp = 1'b1;
    repeat (3) step();
    heartbeat = 1'b0; wd_stp = 1'b0;
    chk_out("latched", 8'd40, 1'b0, 1'b1);
    chk("latched.kick", {7'd0, wd_kick}, kexp());
    clr_fault = 1'b1; step(); clr_fault = 1'b0;
    chk_out("clr_fault", 8'd0, 1'b0, 1'b0);

    // idle ignores ticks
    ticks(2);
    chk_out("idle_tick", 8'd0, 1'b0, 1'b0);

    // clr_fault has no effect while ARMED; arm=0 clears
    arm = 1'b1; step(); sup = 1'b1;
    ticks(5);
    clr_fault = 1'b1; wd_stp = 1'b1; step(); clr_fault = 1'b0; wd_stp = 1'b0;
    chk_out("clr_in_armed", 8'd6, 1'b0, 1'b0);
    arm = 1'b0; step(); sup = 1'b0;
    chk_out("disarm", 8'd0, 1'b0, 1'b0);
    ticks(3);
    chk_out("disarm_tick", 8'd0, 1'b0, 1'b0);

    // async reset in WARN at 35
    arm = 1'b1; step(); sup = 1'b1;
    ticks(35);
    chk_out("warn35", 8'd35, 1'b1, 1'b0);
    #1 rst_n = 1'b0; kick_n = 0; sup = 1'b0;
    #1;
    chk_out("async_rst", 8'd0, 1'b0, 1'b0);
    chk("async_rst.kick", {7'd0, wd_kick}, 8'd0);
    #3 rst_n = 1'b1;
    step(); sup = 1'b1;
    ticks(1);
    chk_out("post_rst", 8'd1, 1'b0, 1'b0);
    chk("post_rst.kick", {7'd0, wd_kick}, kexp());

    // saturating counter: 256 increments from 0 must stick at FF
    s_clr = 1'b1; step(); s_clr = 1'b0;
    chk("sat.clr0", s_cnt, 8'd0);
    s_inc = 1'b1;
    repeat (254) step();
    chk("sat.254", s_cnt, 8'd254);
    repeat (2) step();
    chk("sat.ff", s_cnt, 8'hFF);
    repeat (3) step();
    chk("sat.hold", s_cnt, 8'hFF);
    s_clr = 1'b1; step(); s_clr = 1'b0; s_inc = 1'b0;
    chk("sat.clr", s_cnt, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
